// File: rtl/axi_addr_req_fifo.sv
// AXI AR/AW address-channel front end: legality-checks each burst and queues it
// in a first-word-fall-through FIFO. Optional 4KB crossing check: ADDR_4K_BOUNDARY_CHECK_EN.
module axi_addr_req_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axvalid_i,
  output logic                     s_axready_o,
  input  logic [31:0]              s_axaddr_i,
  input  logic [7:0]               s_axlen_i,
  input  logic [2:0]               s_axsize_i,
  input  logic [1:0]               s_axburst_i,
  input  logic [2:0]               s_axprot_i,
  input  logic [ID_W-1:0]          s_axid_i,
  output logic [31:0]              burst_addr_o,
  output logic [7:0]               burst_len_o,
  output logic [2:0]               burst_size_o,
  output logic [1:0]               burst_name_o,
  output logic [2:0]               burst_prot_o,
  output logic [ID_W-1:0]          burst_id_o,
  output logic                     burst_err_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic                     trans_done_i,
  output logic                     underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef struct packed {
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [2:0]      prot;
    logic [ID_W-1:0] id;
    logic            err;
  } req_t;

  req_t            r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_empty;
  logic            r_full;
  logic            r_underflow;

  logic            w_push;
  logic            w_pop;
  logic            w_err;
  logic [CW-1:0]   w_count_nxt;
  req_t            w_entry;
  req_t            w_head;

`ifdef ADDR_4K_BOUNDARY_CHECK_EN
  // 17 bits hold the worst case 0xFFF + (256 << 7) without truncation.
  logic [16:0]     w_span;
  logic [16:0]     w_end;
  assign w_span = ({9'd0, s_axlen_i} + 17'd1) << s_axsize_i;
  assign w_end  = {5'd0, s_axaddr_i[11:0]} + w_span;
`endif

  // NOTE: combinational logic gets a default first so no path can infer a latch.
  always_comb begin
    w_err = 1'b0;
    if (s_axburst_i == BURST_RSVD) w_err = 1'b1;
    if (s_axsize_i > 3'd2)         w_err = 1'b1;
    if (s_axburst_i == BURST_WRAP &&
        !(s_axlen_i == 8'd1 || s_axlen_i == 8'd3 || s_axlen_i == 8'd7 || s_axlen_i == 8'd15))
      w_err = 1'b1;
    if (s_axburst_i == BURST_FIXED && s_axlen_i > 8'd15) w_err = 1'b1;
`ifdef ADDR_4K_BOUNDARY_CHECK_EN
    if (s_axburst_i == BURST_INCR && w_end > 17'd4096) w_err = 1'b1;
`endif
  end

  assign w_entry = '{addr:  s_axaddr_i,
                     len:   s_axlen_i,
                     size:  s_axsize_i,
                     burst: s_axburst_i,
                     prot:  s_axprot_i,
                     id:    s_axid_i,
                     err:   w_err};

  // Ready depends only on registered state, never on s_axvalid_i.
  assign w_push = s_axvalid_i & ~r_full;
  assign w_pop  = trans_done_i & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (trans_done_i && r_empty) r_underflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the head is only meaningful while empty_o is low.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  assign burst_addr_o = w_head.addr;
  assign burst_len_o  = w_head.len;
  assign burst_size_o = w_head.size;
  assign burst_name_o = w_head.burst;
  assign burst_prot_o = w_head.prot;
  assign burst_id_o   = w_head.id;
  assign burst_err_o  = w_head.err;

  assign s_axready_o = ~r_full;
  assign empty_o     = r_empty;
  assign full_o      = r_full;
  assign count_o     = r_count;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_axi_addr_req_fifo.sv
// Directed bench for axi_addr_req_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for pointer wrap and mid-stream reset.
module tb_axi_addr_req_fifo;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

`ifdef ADDR_4K_BOUNDARY_CHECK_EN
  localparam logic K4_ERR = 1'b1;
`else
  localparam logic K4_ERR = 1'b0;
`endif

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            s_axvalid_i;
  logic            s_axready_o;
  logic [31:0]     s_axaddr_i;
  logic [7:0]      s_axlen_i;
  logic [2:0]      s_axsize_i;
  logic [1:0]      s_axburst_i;
  logic [2:0]      s_axprot_i;
  logic [ID_W-1:0] s_axid_i;
  logic [31:0]     burst_addr_o;
  logic [7:0]      burst_len_o;
  logic [2:0]      burst_size_o;
  logic [1:0]      burst_name_o;
  logic [2:0]      burst_prot_o;
  logic [ID_W-1:0] burst_id_o;
  logic            burst_err_o;
  logic            empty_o;
  logic            full_o;
  logic [2:0]      count_o;
  logic            trans_done_i;
  logic            underflow_o;

  axi_addr_req_fifo #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axvalid_i  (s_axvalid_i),
    .s_axready_o  (s_axready_o),
    .s_axaddr_i   (s_axaddr_i),
    .s_axlen_i    (s_axlen_i),
    .s_axsize_i   (s_axsize_i),
    .s_axburst_i  (s_axburst_i),
    .s_axprot_i   (s_axprot_i),
    .s_axid_i     (s_axid_i),
    .burst_addr_o (burst_addr_o),
    .burst_len_o  (burst_len_o),
    .burst_size_o (burst_size_o),
    .burst_name_o (burst_name_o),
    .burst_prot_o (burst_prot_o),
    .burst_id_o   (burst_id_o),
    .burst_err_o  (burst_err_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .trans_done_i (trans_done_i),
    .underflow_o  (underflow_o)
  );

  always #5 aclk = ~aclk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        done;
    logic        e_empty;
    logic        e_full;
    logic [2:0]  e_count;
    logic        e_uf;
    logic        chk_head;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                              logic [1:0] burst, logic done, logic e_empty, logic e_full,
                              logic [2:0] e_count, logic e_uf, logic chk_head,
                              logic [31:0] e_addr, logic e_err);
    vec_t t;
    t.v = v; t.addr = addr; t.len = len; t.size = size; t.burst = burst; t.done = done;
    t.e_empty = e_empty; t.e_full = e_full; t.e_count = e_count; t.e_uf = e_uf;
    t.chk_head = chk_head; t.e_addr = e_addr; t.e_err = e_err;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst,
                       input logic [ID_W-1:0] id, input logic done);
    s_axvalid_i  = v;
    s_axaddr_i   = addr;
    s_axlen_i    = len;
    s_axsize_i   = size;
    s_axburst_i  = burst;
    s_axprot_i   = 3'b010;
    s_axid_i     = id;
    trans_done_i = done;
  endtask

  vec_t tbl [26];

  initial begin
    logic [31:0] q_addr [$];
    logic [3:0]  q_id [$];
    logic        do_push, do_pop;

    // valid addr        len    size  burst  done | empty full cnt uf  head addr        err
    tbl[0]  = mk(1, 32'h1000_0004, 8'd3,  3'd2, 2'b01, 0,  0, 0, 3'd1, 0,  1, 32'h1000_0004, 0);
    tbl[1]  = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 1,  1, 0, 3'd0, 0,  0, 32'h0,         0);
    tbl[2]  = mk(1, 32'h100,       8'd0,  3'd2, 2'b01, 0,  0, 0, 3'd1, 0,  1, 32'h100,       0);
    tbl[3]  = mk(1, 32'h200,       8'd0,  3'd2, 2'b01, 0,  0, 0, 3'd2, 0,  1, 32'h100,       0);
    tbl[4]  = mk(1, 32'h300,       8'd0,  3'd2, 2'b01, 0,  0, 0, 3'd3, 0,  1, 32'h100,       0);
    tbl[5]  = mk(1, 32'h400,       8'd0,  3'd2, 2'b01, 0,  0, 1, 3'd4, 0,  1, 32'h100,       0);
    tbl[6]  = mk(1, 32'h500,       8'd0,  3'd2, 2'b01, 0,  0, 1, 3'd4, 0,  1, 32'h100,       0);
    tbl[7]  = mk(1, 32'h500,       8'd0,  3'd2, 2'b01, 1,  0, 0, 3'd3, 0,  1, 32'h200,       0);
    tbl[8]  = mk(1, 32'h500,       8'd0,  3'd2, 2'b01, 0,  0, 1, 3'd4, 0,  1, 32'h200,       0);
    tbl[9]  = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 1,  0, 0, 3'd3, 0,  1, 32'h300,       0);
    tbl[10] = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 1,  0, 0, 3'd2, 0,  1, 32'h400,       0);
    tbl[11] = mk(1, 32'h600,       8'd0,  3'd2, 2'b01, 1,  0, 0, 3'd2, 0,  1, 32'h500,       0);
    tbl[12] = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 1,  0, 0, 3'd1, 0,  1, 32'h600,       0);
    tbl[13] = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 1,  1, 0, 3'd0, 0,  0, 32'h0,         0);
    tbl[14] = mk(1, 32'h10,        8'd2,  3'd2, 2'b10, 0,  0, 0, 3'd1, 0,  1, 32'h10,        1);
    tbl[15] = mk(1, 32'h20,        8'd7,  3'd2, 2'b10, 1,  0, 0, 3'd1, 0,  1, 32'h20,        0);
    tbl[16] = mk(1, 32'h30,        8'd0,  3'd2, 2'b11, 1,  0, 0, 3'd1, 0,  1, 32'h30,        1);
    tbl[17] = mk(1, 32'h40,        8'd0,  3'd3, 2'b01, 1,  0, 0, 3'd1, 0,  1, 32'h40,        1);
    tbl[18] = mk(1, 32'h50,        8'd16, 3'd2, 2'b00, 1,  0, 0, 3'd1, 0,  1, 32'h50,        1);
    tbl[19] = mk(1, 32'h60,        8'd15, 3'd2, 2'b00, 1,  0, 0, 3'd1, 0,  1, 32'h60,        0);
    tbl[20] = mk(1, 32'hFF8,       8'd3,  3'd2, 2'b01, 1,  0, 0, 3'd1, 0,  1, 32'hFF8,       K4_ERR);
    tbl[21] = mk(1, 32'hFF0,       8'd3,  3'd2, 2'b01, 1,  0, 0, 3'd1, 0,  1, 32'hFF0,       0);
    tbl[22] = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 1,  1, 0, 3'd0, 0,  0, 32'h0,         0);
    tbl[23] = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 1,  1, 0, 3'd0, 1,  0, 32'h0,         0);
    tbl[24] = mk(0, 32'h0,         8'd0,  3'd0, 2'b01, 0,  1, 0, 3'd0, 1,  0, 32'h0,         0);
    tbl[25] = mk(1, 32'h70,        8'd0,  3'd2, 2'b01, 1,  0, 0, 3'd1, 1,  1, 32'h70,        0);

    aresetn = 1'b0;
    drive(0, 32'h0, 8'd0, 3'd0, 2'b01, '0, 0);
    #23;
    check("reset_empty", 32'(empty_o), 32'd1);
    check("reset_full", 32'(full_o), 32'd0);
    check("reset_count", 32'(count_o), 32'd0);
    check("reset_ready", 32'(s_axready_o), 32'd1);
    check("reset_uf", 32'(underflow_o), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge aclk);
      drive(tbl[i].v, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 4'(i), tbl[i].done);
      @(posedge aclk);
      #1;
      check($sformatf("v%0d_empty", i), 32'(empty_o), 32'(tbl[i].e_empty));
      check($sformatf("v%0d_full", i), 32'(full_o), 32'(tbl[i].e_full));
      check($sformatf("v%0d_count", i), 32'(count_o), 32'(tbl[i].e_count));
      check($sformatf("v%0d_ready", i), 32'(s_axready_o), 32'(!tbl[i].e_full));
      check($sformatf("v%0d_uf", i), 32'(underflow_o), 32'(tbl[i].e_uf));
      if (tbl[i].chk_head) begin
        check($sformatf("v%0d_addr", i), burst_addr_o, tbl[i].e_addr);
        check($sformatf("v%0d_err", i), 32'(burst_err_o), 32'(tbl[i].e_err));
      end
    end

    // Drain the single leftover entry, then run 8 pushes / 8 pops through the wrap.
    @(negedge aclk);
    drive(0, 32'h0, 8'd0, 3'd0, 2'b01, '0, 1);
    @(posedge aclk);
    #1;
    check("drain_empty", 32'(empty_o), 32'd1);

    for (int c = 0; c < 10; c++) begin
      do_push = (c < 8);
      do_pop  = (c >= 2);
      @(negedge aclk);
      drive(do_push, 32'h2000_0000 + 32'(c) * 32'h40, 8'd1, 3'd2, 2'b01, 4'(c + 3), do_pop);
      @(posedge aclk);
      #1;
      if (do_pop && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_id.pop_front());
      end
      if (do_push) begin
        q_addr.push_back(32'h2000_0000 + 32'(c) * 32'h40);
        q_id.push_back(4'(c + 3));
      end
      check($sformatf("wrap%0d_count", c), 32'(count_o), 32'(q_addr.size()));
      if (q_addr.size() > 0) begin
        check($sformatf("wrap%0d_addr", c), burst_addr_o, q_addr[0]);
        check($sformatf("wrap%0d_id", c), 32'(burst_id_o), 32'(q_id[0]));
        check($sformatf("wrap%0d_len", c), 32'(burst_len_o), 32'd1);
      end
    end
    check("wrap_end_empty", 32'(empty_o), 32'd1);

    // Fill to three entries, then pull reset between edges.
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      drive(1, 32'h3000_0000 + 32'(k), 8'd0, 3'd2, 2'b01, '0, 0);
    end
    @(negedge aclk);
    drive(0, 32'h0, 8'd0, 3'd0, 2'b01, '0, 0);
    check("pre_rst_count", 32'(count_o), 32'd3);
    check("pre_rst_uf", 32'(underflow_o), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_uf", 32'(underflow_o), 32'd0);
    check("rst_ready", 32'(s_axready_o), 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    drive(1, 32'h4000_0000, 8'd0, 3'd2, 2'b01, 4'hA, 0);
    @(posedge aclk);
    #1;
    check("post_rst_count", 32'(count_o), 32'd1);
    check("post_rst_addr", burst_addr_o, 32'h4000_0000);
    @(negedge aclk);
    drive(0, 32'h0, 8'd0, 3'd0, 2'b01, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
